// File: rtl/data_memory.sv
// Word-organized data memory for the single-cycle CPU memory stage.
// Synchronous stores, combinational loads, asynchronous clear of the whole array.
module data_memory #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData
);

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] index;
    logic                 in_range;

    assign index    = Address[ADDR_BITS+1:2];
    assign in_range = (Address[31:ADDR_BITS+2] == '0);

    // Byte offset is ignored: misaligned accesses hit the containing word.
    logic unused_byte_offset;
    assign unused_byte_offset = ^Address[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite && in_range) begin
            mem[index] <= WriteData;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && in_range) begin
            ReadData = mem[index];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    int unsigned vectors;
    int unsigned miscompares;

    logic [31:0] model_mem [256];

    data_memory #(
        .DEPTH    (256),
        .ADDR_BITS(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 1 KiB byte space, anything at or above 0x400 reads as zero.
    function automatic logic [31:0] expected(input logic [31:0] a, input logic rd);
        if (!rd || a >= 32'h400) return 32'h0;
        return model_mem[a / 4];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        if (rst_n && a < 32'h400) model_mem[a / 4] = d;
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0;
        addrs[1] = 32'h3FC;
        @(negedge clk);
        rst_n = 1'b1;
        MemRead = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Address = addrs[i];
            #1;
            vectors++;
            if (ReadData !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read addr=%h got=%h want=%h", addrs[i], ReadData, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        write_word(32'h4, 32'hAAAA_AAAA);
        MemRead = 1'b1;
        Address = 32'h4;
        #1;
        vectors++;
        if (ReadData !== 32'hAAAA_AAAA) begin
            miscompares++;
            $display("FAIL write_read addr=4 got=%h want=%h", ReadData, 32'hAAAA_AAAA);
        end
        Address = 32'h8;
        #1;
        vectors++;
        if (ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL unwritten_read addr=8 got=%h want=%h", ReadData, 32'h0);
        end
    endtask

    task automatic test_read_gating();
        Address = 32'h4;
        MemRead = 1'b0;
        #1;
        vectors++;
        if (ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL read_gate_off got=%h want=%h", ReadData, 32'h0);
        end
        MemRead = 1'b1;
        #1;
        vectors++;
        if (ReadData !== 32'hAAAA_AAAA) begin
            miscompares++;
            $display("FAIL read_gate_on got=%h want=%h", ReadData, 32'hAAAA_AAAA);
        end
    endtask

    task automatic test_misaligned_boundary();
        write_word(32'h7, 32'h1234_5678);
        MemRead = 1'b1;
        Address = 32'h4;
        #1;
        vectors++;
        if (ReadData !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL misaligned got=%h want=%h", ReadData, 32'h1234_5678);
        end
        write_word(32'h3FC, 32'hDEAD_BEEF);
        Address = 32'h3FC;
        #1;
        vectors++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL top_word got=%h want=%h", ReadData, 32'hDEAD_BEEF);
        end
        write_word(32'h400, 32'hCAFE_F00D);
        Address = 32'h0;
        #1;
        vectors++;
        if (ReadData !== expected(32'h0, 1'b1)) begin
            miscompares++;
            $display("FAIL oob_write_alias got=%h want=%h", ReadData, expected(32'h0, 1'b1));
        end
        Address = 32'h400;
        #1;
        vectors++;
        if (ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL oob_read got=%h want=%h", ReadData, 32'h0);
        end
    endtask

    task automatic test_simultaneous();
        write_word(32'h10, 32'h1);
        @(negedge clk);
        Address   = 32'h10;
        WriteData = 32'h2;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        vectors++;
        if (ReadData !== 32'h1) begin
            miscompares++;
            $display("FAIL rw_before_edge got=%h want=%h", ReadData, 32'h1);
        end
        @(posedge clk);
        model_mem[4] = 32'h2;
        #1;
        MemWrite = 1'b0;
        vectors++;
        if (ReadData !== 32'h2) begin
            miscompares++;
            $display("FAIL rw_after_edge got=%h want=%h", ReadData, 32'h2);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        Address   = 32'h20;
        WriteData = 32'h1111_1111;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        WriteData = 32'h2222_2222;
        @(posedge clk);
        model_mem[8] = 32'h2222_2222;
        #1;
        MemWrite = 1'b0;
        vectors++;
        if (ReadData !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL back_to_back got=%h want=%h", ReadData, 32'h2222_2222);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic        rd;
        logic        wr;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            a  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 32'h3FF));
            d  = $urandom();
            rd = 1'($urandom_range(0, 3) != 0);
            wr = 1'($urandom_range(0, 1));
            Address   = a;
            WriteData = d;
            MemRead   = rd;
            MemWrite  = wr;
            #1;
            vectors++;
            if (ReadData !== expected(a, rd)) begin
                miscompares++;
                $display("FAIL rand_pre n=%0d addr=%h got=%h want=%h", n, a, ReadData,
                         expected(a, rd));
            end
            @(posedge clk);
            if (wr && a < 32'h400) model_mem[a / 4] = d;
            #1;
            MemWrite = 1'b0;
            vectors++;
            if (ReadData !== expected(a, rd)) begin
                miscompares++;
                $display("FAIL rand_post n=%0d addr=%h got=%h want=%h", n, a, ReadData,
                         expected(a, rd));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'h40;
        addrs[1] = 32'h44;
        addrs[2] = 32'h3FC;
        for (int i = 0; i < 3; i++) write_word(addrs[i], 32'h5A5A_0000 + i + 1);
        @(negedge clk);
        MemRead = 1'b1;
        #2;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            Address = addrs[i];
            #0.5;
            vectors++;
            if (ReadData !== 32'h0) begin
                miscompares++;
                $display("FAIL async_clear addr=%h got=%h want=%h", addrs[i], ReadData, 32'h0);
            end
        end
        write_word(32'h40, 32'h7777_7777);
        Address = 32'h40;
        #1;
        vectors++;
        if (ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL write_in_reset got=%h want=%h", ReadData, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        write_word(32'h40, 32'h8888_8888);
        Address = 32'h40;
        #1;
        vectors++;
        if (ReadData !== 32'h8888_8888) begin
            miscompares++;
            $display("FAIL write_after_reset got=%h want=%h", ReadData, 32'h8888_8888);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        Address     = 32'h0;
        WriteData   = 32'h0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_read_gating();
        test_misaligned_boundary();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
